// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the shared-RAM arbiter.
package ram_arb_pkg;

  typedef enum logic {ARB, LOCKED} arb_state_t;

  // Index of the set bit in a one-hot vector (0 when the vector is empty).
  function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (oh[i[4:0]]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Core-side and RAM-side buses of the shared-RAM arbiter.
interface ram_arbiter_if #(
  parameter int N_CORES    = 4,
  parameter int WIDTH      = 12,
  parameter int ADDR_WIDTH = 8
);
  logic [N_CORES-1:0]            core_req;
  logic [N_CORES-1:0]            core_wrEn;
  logic [N_CORES-1:0]            core_lock;
  logic [N_CORES*ADDR_WIDTH-1:0] core_addr;
  logic [N_CORES*WIDTH-1:0]      core_dataIn;
  logic [N_CORES-1:0]            core_gnt;
  logic [N_CORES-1:0]            core_rdValid;
  logic [WIDTH-1:0]              core_dataOut;
  logic                          ram_wrEn;
  logic [ADDR_WIDTH-1:0]         ram_addr;
  logic [WIDTH-1:0]              ram_dataIn;
  logic [WIDTH-1:0]              ram_dataOut;

  // Arbiter side.
  modport slave (
    input  core_req, core_wrEn, core_lock, core_addr, core_dataIn, ram_dataOut,
    output core_gnt, core_rdValid, core_dataOut, ram_wrEn, ram_addr, ram_dataIn
  );

  // Core array / RAM side.
  modport master (
    output core_req, core_wrEn, core_lock, core_addr, core_dataIn, ram_dataOut,
    input  core_gnt, core_rdValid, core_dataOut, ram_wrEn, ram_addr, ram_dataIn
  );
endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
module rr_priority_picker
  import ram_arb_pkg::*;
#(
  parameter int N_CORES  = 4,
  parameter int ID_WIDTH = $clog2(N_CORES)
) (
  input  logic [N_CORES-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [N_CORES-1:0]  gnt,
  output logic [ID_WIDTH-1:0] idx
);
  logic                found;
  logic [ID_WIDTH-1:0] c;

  // Rotating search starting at ptr; only the first hit is granted.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    c     = '0;
    for (int k = 0; k < N_CORES; k++) begin
      c = ID_WIDTH'((32'(ptr) + 32'(k)) % 32'(N_CORES));
      if (!found && req[c]) begin
        gnt[c] = 1'b1;
        found  = 1'b1;
      end
    end
    idx = ID_WIDTH'(onehot_to_idx(32'(gnt)));
  end
endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port, 1-cycle-read-latency RAM among N_CORES cores with
// round-robin grant, optional ownership lock and read-data return tagging.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int N_CORES    = 4,
  parameter int WIDTH      = 12,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int ID_WIDTH   = $clog2(N_CORES)
) (
  input logic         clk,
  input logic         rstN,
  ram_arbiter_if.slave bus
);
  arb_state_t          state;
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH-1:0] owner;
  logic                rd_pend;
  logic [ID_WIDTH-1:0] rd_tag;

  logic [N_CORES-1:0]  pick_gnt;
  logic [ID_WIDTH-1:0] pick_idx;
  logic [N_CORES-1:0]  gnt;
  logic [ID_WIDTH-1:0] gnt_idx;
  logic                any_gnt;
  logic [ID_WIDTH-1:0] next_ptr;

  rr_priority_picker #(
    .N_CORES (N_CORES),
    .ID_WIDTH(ID_WIDTH)
  ) u_picker (
    .req(bus.core_req),
    .ptr(rr_ptr),
    .gnt(pick_gnt),
    .idx(pick_idx)
  );

  // Zero-cycle grant: picker in ARB, owner only in LOCKED, nothing while in reset.
  always_comb begin
    gnt     = '0;
    gnt_idx = (state == ARB) ? pick_idx : owner;
    if (rstN) begin
      if (state == ARB) gnt = pick_gnt;
      else if (bus.core_req[owner]) gnt[owner] = 1'b1;
    end
    any_gnt  = |gnt;
    next_ptr = (gnt_idx == ID_WIDTH'(N_CORES - 1)) ? '0 : gnt_idx + ID_WIDTH'(1);
  end

  // RAM-side AND-OR mux of the granted core; all zero when nobody is granted.
  always_comb begin
    bus.ram_addr   = '0;
    bus.ram_dataIn = '0;
    bus.ram_wrEn   = 1'b0;
    for (int i = 0; i < N_CORES; i++) begin
      if (gnt[i]) begin
        bus.ram_addr   = bus.core_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        bus.ram_dataIn = bus.core_dataIn[i*WIDTH +: WIDTH];
        bus.ram_wrEn   = bus.core_wrEn[i];
      end
    end
  end

  // Read-return side: registered one-hot valid, data passes straight through.
  always_comb begin
    bus.core_rdValid = '0;
    if (rd_pend) bus.core_rdValid[rd_tag] = 1'b1;
    bus.core_gnt     = gnt;
    bus.core_dataOut = bus.ram_dataOut;
  end

  // Arbitration FSM, round-robin pointer, owner and read-pending flag.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state   <= ARB;
      rr_ptr  <= '0;
      owner   <= '0;
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= any_gnt & ~bus.core_wrEn[gnt_idx];
      case (state)
        ARB: begin
          if (any_gnt) begin
            rr_ptr <= next_ptr;
            if (bus.core_lock[gnt_idx]) begin
              owner <= gnt_idx;
              state <= LOCKED;
            end
          end
        end
        LOCKED: begin
          // The unlocking cycle's access is still granted above; leave afterwards.
          if (!bus.core_lock[owner]) state <= ARB;
        end
        default: state <= ARB;
      endcase
    end
  end

  // Read tag is datapath only; it is qualified by rd_pend.
  always_ff @(posedge clk) begin
    if (any_gnt) rd_tag <= gnt_idx;
  end
endmodule
